sdc_wb_init_sequencer: RTL
==========================

SDC_WB_INIT_SEQUENCER -- requirements
Module: sdc_wb_init_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, meaning the number of init table entries (1..16).
REQ-002 SHALL have parameter INIT_ADDRS, default {8'h24,8'h20,8'h1C,8'h18}, meaning the flat NUM_REGS x 8-bit register addresses; entry 0 is in the LSBs.
REQ-003 SHALL have parameter INIT_DATA, default {32'd1,32'h7FFF,32'd1,32'h7FFF}, meaning the flat NUM_REGS x 32-bit write values; entry 0 is in the LSBs.
REQ-004 SHALL have parameter VERIFY_MASK, default 32'h00FF_FFFF, meaning the bits compared on read-back.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum number of cycles with stb high and no ack.
REQ-006 SHALL have parameter MAX_RETRIES, default 2, meaning the number of rewrites allowed per entry after a verify mismatch.
REQ-007 SHALL have ports: clk in 1, the single clock; reset in 1, the reset.
REQ-008 SHALL have ports: start in 1 (one-cycle request); busy out 1; done out 1; fail out 1; fail_code out 2 (01 timeout, 10 mismatch); fail_index out 4.
REQ-009 SHALL have ports: wb_adr_o out 8; wb_dat_o out 32; wb_dat_i in 32; wb_sel_o out 4; wb_we_o out 1; wb_cyc_o out 1; wb_stb_o out 1; wb_ack_i in 1.
REQ-010 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-011 SHALL use states IDLE, WRITE, GAP, READ, DONE and FAIL.
REQ-012 SHALL, on start in IDLE, DONE or FAIL, clear done, fail and the entry index, and enter WRITE on the next edge; start SHALL be ignored while busy.
REQ-013 SHALL, in WRITE, drive cyc=stb=we=1, sel=4'b1111, and adr/dat from the table entry, holding all of them stable until ack.
REQ-014 SHALL, on ack, drop cyc/stb/we on the following edge and spend exactly one GAP cycle with cyc=0 before the next bus cycle.
REQ-015 SHALL, in READ, drive cyc=stb=1 and we=0 at the same address.
REQ-016 SHALL, on ack in READ, compare (wb_dat_i & VERIFY_MASK) against (INIT_DATA entry & VERIFY_MASK).
REQ-017 SHALL, on a READ match, advance the index and go to WRITE; after the last entry it SHALL go to DONE.
REQ-018 SHALL, on a READ mismatch with retries < MAX_RETRIES, increment retries and rewrite the same entry; otherwise it SHALL go to FAIL with fail_code=10.
REQ-019 SHALL reset the retry counter on every index advance.
REQ-020 SHALL run a timeout counter that counts cycles with stb=1 and ack=0, and clears on ack or when stb is low.
REQ-021 SHALL, when the timeout counter reaches ACK_TIMEOUT, drop cyc/stb next edge and go to FAIL with fail_code=01.
REQ-022 SHALL, when ack and timeout occur in the same cycle, let ack win.
REQ-023 SHALL set fail_index to the index of the failing entry.
REQ-024 SHALL hold busy=1 in WRITE, GAP and READ.
REQ-025 SHALL make done and fail sticky until the next start or reset; they SHALL be mutually exclusive.
REQ-026 SHALL make the latency from start to first stb exactly 1 cycle.
REQ-027 SHALL make the per-entry cost (with verify and zero-wait acks) 4 cycles: write, gap, read, gap.
REQ-028 SHALL ignore ack outside cyc.

Reset
REQ-029 SHALL, on reset, put the FSM in IDLE, clear all counters, and drive every output to 0, including wb_adr_o, wb_dat_o and wb_sel_o.
REQ-030 SHALL, on reset asserted mid-transfer, deassert cyc/stb/we on that edge without waiting for ack; the sequence SHALL NOT resume.
REQ-031 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL use macro SDC_INIT_VERIFY_EN to compile in the READ state, the compare logic, the retry counter, and fail_code=10.
REQ-033 SHALL, without SDC_INIT_VERIFY_EN, go WRITE, GAP, then the next entry; the per-entry cost SHALL be 2 cycles; fail_code SHALL only ever be 01; MAX_RETRIES and VERIFY_MASK SHALL be unused.

Structure
REQ-034 SHALL take the sdc register address constants (ARGUMENT 00 through DATA_XFER_ADDRESS 60), the state encoding and the fail_code constants from shared package sdc_pkg.
REQ-035 SHALL place the Wishbone single-transfer handshake plus the timeout counter in sub-module sdc_wb_xfer, which returns ack_ok, timeout and rdata to the FSM.

Verification
REQ-036 SHALL cover: defaults, zero-wait slave, pulse start -> writes 18/7FFF, 1C/1, 20/7FFF, 24/1 in order; done=1 after 16 cycles (verify) or 8 cycles (no verify); fail=0.
REQ-037 SHALL cover: slave with ack delayed 3 cycles -> each stb held 4 cycles with adr/dat stable; done=1; busy never drops mid-sequence.
REQ-038 SHALL cover: slave returns 0x0000_0000 at 0x1C on every read, MAX_RETRIES=2 -> 3 writes to 0x1C, then fail=1, fail_code=10, fail_index=1; no access to 0x20.
REQ-039 SHALL cover: slave never acks at 0x20, ACK_TIMEOUT=255 -> stb high for 255 cycles, then cyc=0; fail_code=01; fail_index=2.
REQ-040 SHALL cover: reset asserted during the stb of the second write -> cyc/stb=0 the next cycle; all outputs 0; a subsequent start restarts from 0x18.
REQ-041 SHALL cover: start pulsed while busy -> ignored; start pulsed after fail -> a full sequence reruns and ends with done=1.

Source files
------------

// File: rtl/sdc_pkg.sv
// ============================================================================
// Module      : sdc_pkg
// Description : Shared SD-controller register map, init-sequencer state
//               encoding and failure codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdc_pkg;

    localparam logic [7:0] c_ADDR_ARGUMENT          = 8'h00;
    localparam logic [7:0] c_ADDR_COMMAND           = 8'h04;
    localparam logic [7:0] c_ADDR_RESP_1            = 8'h08;
    localparam logic [7:0] c_ADDR_RESP_2            = 8'h0C;
    localparam logic [7:0] c_ADDR_RESP_3            = 8'h10;
    localparam logic [7:0] c_ADDR_RESP_4            = 8'h14;
    localparam logic [7:0] c_ADDR_DATA_TIMEOUT      = 8'h18;
    localparam logic [7:0] c_ADDR_CONTROLLER        = 8'h1C;
    localparam logic [7:0] c_ADDR_CMD_TIMEOUT       = 8'h20;
    localparam logic [7:0] c_ADDR_CLOCK_DIVIDER     = 8'h24;
    localparam logic [7:0] c_ADDR_SOFTWARE_RESET    = 8'h28;
    localparam logic [7:0] c_ADDR_POWER_CONTROL     = 8'h2C;
    localparam logic [7:0] c_ADDR_CAPABILITY        = 8'h30;
    localparam logic [7:0] c_ADDR_CMD_EVENT_STATUS  = 8'h34;
    localparam logic [7:0] c_ADDR_CMD_EVENT_ENABLE  = 8'h38;
    localparam logic [7:0] c_ADDR_DATA_EVENT_STATUS = 8'h3C;
    localparam logic [7:0] c_ADDR_DATA_EVENT_ENABLE = 8'h40;
    localparam logic [7:0] c_ADDR_BLOCK_SIZE        = 8'h44;
    localparam logic [7:0] c_ADDR_BLOCK_COUNT       = 8'h48;
    localparam logic [7:0] c_ADDR_DATA_XFER_ADDRESS = 8'h60;

    localparam logic [1:0] c_FAIL_NONE     = 2'b00;
    localparam logic [1:0] c_FAIL_TIMEOUT  = 2'b01;
    localparam logic [1:0] c_FAIL_MISMATCH = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_GAP   = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } init_state_e;

endpackage

`default_nettype wire

// File: rtl/sdc_wb_xfer.sv
// ============================================================================
// Module      : sdc_wb_xfer
// Description : Wishbone single-transfer master handshake with stalled-ack
//               timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdc_wb_xfer #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [7:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_ok_o,
    output logic        timeout_o,
    output logic [31:0] rdata_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam int              c_CW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LIMIT = c_CW'(ACK_TIMEOUT - 1);

    logic [c_CW-1:0] cnt_q, cnt_d;

    // The cycle that would take the stall count to ACK_TIMEOUT raises timeout.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!req_i || wb_ack_i || (cnt_q == c_LIMIT)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ack_ok_o  = req_i & wb_ack_i;
    assign timeout_o = req_i & ~wb_ack_i & (cnt_q == c_LIMIT);
    assign rdata_o   = wb_dat_i;

    assign wb_cyc_o  = req_i;
    assign wb_stb_o  = req_i;
    assign wb_we_o   = req_i & we_i;
    assign wb_sel_o  = req_i ? 4'b1111 : 4'b0000;
    assign wb_adr_o  = req_i ? adr_i : 8'h00;
    assign wb_dat_o  = (req_i & we_i) ? dat_i : 32'h0;

endmodule

`default_nettype wire

// File: rtl/sdc_wb_init_sequencer.sv
// ============================================================================
// Module      : sdc_wb_init_sequencer
// Description : Writes a register table over Wishbone, optionally reading
//               each entry back with retries. Read-back is compiled in by
//               defining SDC_INIT_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdc_wb_init_sequencer
    import sdc_pkg::*;
#(
    parameter int                     NUM_REGS    = 4,
    parameter logic [NUM_REGS*8-1:0]  INIT_ADDRS  = {8'h24, 8'h20, 8'h1C, 8'h18},
    parameter logic [NUM_REGS*32-1:0] INIT_DATA   = {32'd1, 32'h7FFF, 32'd1, 32'h7FFF},
    parameter logic [31:0]            VERIFY_MASK = 32'h00FF_FFFF,
    parameter int                     ACK_TIMEOUT = 255,
    parameter int                     MAX_RETRIES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [1:0]  fail_code,
    output logic [3:0]  fail_index,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    localparam logic [3:0] c_LAST_IDX = 4'(NUM_REGS - 1);

    init_state_e state_q, state_d;
    init_state_e gap_next_q, gap_next_d;
    logic [3:0]  idx_q, idx_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [3:0]  fail_index_q, fail_index_d;

    logic        w_req;
    logic        w_we;
    logic        w_ack_ok;
    logic        w_timeout;
    logic [7:0]  w_entry_adr;
    logic [31:0] w_entry_dat;

    // Table padded to 16 entries so the 4-bit index always selects in range.
    logic [7:0]  w_adr_tbl [16];
    logic [31:0] w_dat_tbl [16];

    for (genvar g = 0; g < 16; g++) begin : g_tbl
        if (g < NUM_REGS) begin : g_used
            assign w_adr_tbl[g] = INIT_ADDRS[g*8 +: 8];
            assign w_dat_tbl[g] = INIT_DATA[g*32 +: 32];
        end else begin : g_unused
            assign w_adr_tbl[g] = 8'h00;
            assign w_dat_tbl[g] = 32'h0;
        end
    end

    assign w_entry_adr = w_adr_tbl[idx_q];
    assign w_entry_dat = w_dat_tbl[idx_q];

`ifdef SDC_INIT_VERIFY_EN
    localparam logic [3:0] c_MAX_RETRY = 4'(MAX_RETRIES);

    logic [3:0]  retry_q, retry_d;
    logic [31:0] w_rdata;
    logic        w_match;

    assign w_match = ((w_rdata ^ w_entry_dat) & VERIFY_MASK) == 32'h0;
`endif

    sdc_wb_xfer #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_xfer (
        .clk       (clk),
        .rst       (reset),
        .req_i     (w_req),
        .we_i      (w_we),
        .adr_i     (w_entry_adr),
        .dat_i     (w_entry_dat),
        .ack_ok_o  (w_ack_ok),
        .timeout_o (w_timeout),
`ifdef SDC_INIT_VERIFY_EN
        .rdata_o   (w_rdata),
`else
        .rdata_o   (),
`endif
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i)
    );

    always_comb begin
        state_d      = state_q;
        gap_next_d   = gap_next_q;
        idx_d        = idx_q;
        fail_code_d  = fail_code_q;
        fail_index_d = fail_index_q;
        w_req        = 1'b0;
        w_we         = 1'b0;
`ifdef SDC_INIT_VERIFY_EN
        retry_d      = retry_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d      = ST_WRITE;
                    idx_d        = 4'd0;
                    fail_code_d  = c_FAIL_NONE;
                    fail_index_d = 4'd0;
`ifdef SDC_INIT_VERIFY_EN
                    retry_d      = 4'd0;
`endif
                end
            end
            ST_WRITE: begin
                w_req = 1'b1;
                w_we  = 1'b1;
                if (w_ack_ok) begin
                    state_d = ST_GAP;
`ifdef SDC_INIT_VERIFY_EN
                    gap_next_d = ST_READ;
`else
                    if (idx_q == c_LAST_IDX) begin
                        gap_next_d = ST_DONE;
                    end else begin
                        gap_next_d = ST_WRITE;
                        idx_d      = idx_q + 4'd1;
                    end
`endif
                end else if (w_timeout) begin
                    state_d      = ST_FAIL;
                    fail_code_d  = c_FAIL_TIMEOUT;
                    fail_index_d = idx_q;
                end
            end
`ifdef SDC_INIT_VERIFY_EN
            ST_READ: begin
                w_req = 1'b1;
                if (w_ack_ok) begin
                    if (w_match) begin
                        state_d = ST_GAP;
                        retry_d = 4'd0;
                        if (idx_q == c_LAST_IDX) begin
                            gap_next_d = ST_DONE;
                        end else begin
                            gap_next_d = ST_WRITE;
                            idx_d      = idx_q + 4'd1;
                        end
                    end else if (retry_q < c_MAX_RETRY) begin
                        state_d    = ST_GAP;
                        gap_next_d = ST_WRITE;
                        retry_d    = retry_q + 4'd1;
                    end else begin
                        state_d      = ST_FAIL;
                        fail_code_d  = c_FAIL_MISMATCH;
                        fail_index_d = idx_q;
                    end
                end else if (w_timeout) begin
                    state_d      = ST_FAIL;
                    fail_code_d  = c_FAIL_TIMEOUT;
                    fail_index_d = idx_q;
                end
            end
`endif
            ST_GAP: begin
                state_d = gap_next_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_next_q   <= ST_IDLE;
            idx_q        <= 4'd0;
            fail_code_q  <= c_FAIL_NONE;
            fail_index_q <= 4'd0;
`ifdef SDC_INIT_VERIFY_EN
            retry_q      <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            gap_next_q   <= gap_next_d;
            idx_q        <= idx_d;
            fail_code_q  <= fail_code_d;
            fail_index_q <= fail_index_d;
`ifdef SDC_INIT_VERIFY_EN
            retry_q      <= retry_d;
`endif
        end
    end

    assign busy       = (state_q == ST_WRITE) || (state_q == ST_GAP) || (state_q == ST_READ);
    assign done       = (state_q == ST_DONE);
    assign fail       = (state_q == ST_FAIL);
    assign fail_code  = fail_code_q;
    assign fail_index = fail_index_q;

endmodule

`default_nettype wire
